hsiao_code_decoder: RTL and testbench

//  Pipelined SEC-DED decoder for the Hsiao (13,8) code produced by the memory write-path encoder.

---
 rtl/hsiao_pkg.sv | 45 ++++
 rtl/hsiao_syndrome_calc.sv | 12 +
 rtl/hsiao_code_decoder.sv | 129 ++++++++++++
 tb/tb_hsiao_code_decoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsiao_pkg.sv
// Shared Hsiao (13,8) SEC-DED definitions: widths, H-matrix columns, status codes
// and the parity equations used by both the write-path encoder and this decoder.
package hsiao_pkg;

   localparam int CODE_W = 13;
   localparam int DATA_W = 8;
   localparam int SYN_W  = 5;

   typedef enum logic [1:0] {
      ST_CLEAN = 2'b00,
      ST_CE    = 2'b01,
      ST_UE    = 2'b10
   } status_e;

   localparam logic [SYN_W-1:0] H_P0 = 5'b00001;
   localparam logic [SYN_W-1:0] H_P1 = 5'b00010;
   localparam logic [SYN_W-1:0] H_P2 = 5'b00100;
   localparam logic [SYN_W-1:0] H_P3 = 5'b01000;
   localparam logic [SYN_W-1:0] H_P4 = 5'b10000;
   localparam logic [SYN_W-1:0] H_D0 = 5'b00111;
   localparam logic [SYN_W-1:0] H_D1 = 5'b01110;
   localparam logic [SYN_W-1:0] H_D2 = 5'b01101;
   localparam logic [SYN_W-1:0] H_D3 = 5'b01011;
   localparam logic [SYN_W-1:0] H_D4 = 5'b10011;
   localparam logic [SYN_W-1:0] H_D5 = 5'b10101;
   localparam logic [SYN_W-1:0] H_D6 = 5'b10110;
   localparam logic [SYN_W-1:0] H_D7 = 5'b11001;

   // Indexed by code-bit position: parity bits occupy 0..4, data bits 5..12.
   localparam logic [SYN_W-1:0] H_COL [CODE_W] = '{
      H_P0, H_P1, H_P2, H_P3, H_P4,
      H_D0, H_D1, H_D2, H_D3, H_D4, H_D5, H_D6, H_D7
   };

   function automatic logic [SYN_W-1:0] hsiaoParity(input logic [DATA_W-1:0] d);
      logic [SYN_W-1:0] p;
      p[4] = d[7] ^ d[6] ^ d[5] ^ d[4];
      p[3] = d[7] ^ d[3] ^ d[2] ^ d[1];
      p[2] = d[6] ^ d[5] ^ d[2] ^ d[1] ^ d[0];
      p[1] = d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
      p[0] = d[7] ^ d[5] ^ d[4] ^ d[3] ^ d[2] ^ d[0];
      return p;
   endfunction

endpackage

// File: rtl/hsiao_syndrome_calc.sv
// Combinational syndrome: parity recomputed from the data field, XORed with the
// received parity field. Zero means the codeword is consistent.
module hsiao_syndrome_calc
   import hsiao_pkg::*;
(
   input  logic [CODE_W-1:0] code_i,
   output logic [SYN_W-1:0]  syndrome_o
);

   assign syndrome_o = hsiaoParity(code_i[CODE_W-1:SYN_W]) ^ code_i[SYN_W-1:0];

endmodule

// File: rtl/hsiao_code_decoder.sv
// Two-stage pipelined Hsiao (13,8) SEC-DED decoder with a single global stall
// and saturating corrected/uncorrectable event counters.
module hsiao_code_decoder
   import hsiao_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter bit UE_PASS_RAW = 1'b1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [12:0]       in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic [1:0]        out_status,
   output logic              out_double,
   output logic [4:0]        out_syndrome,
   output logic [3:0]        out_err_pos,
   input  logic              cnt_clear,
   output logic [CNT_W-1:0]  ce_count,
   output logic [CNT_W-1:0]  ue_count
);

   logic                advance;
   logic [SYN_W-1:0]    syndrome;
   logic                s1Valid_q;
   logic [CODE_W-1:0]   s1Code_q;
   logic [SYN_W-1:0]    s1Syn_q;
   logic                outValid_q;
   logic [DATA_W-1:0]   outData_q;
   status_e             outStatus_q;
   logic                outDouble_q;
   logic [SYN_W-1:0]    outSyn_q;
   logic [3:0]          outPos_q;
   logic [CNT_W-1:0]    ceCount_q;
   logic [CNT_W-1:0]    ueCount_q;
   logic [CODE_W-1:0]   flip;
   logic                colMatch;
   logic [3:0]          decPos_d;
   logic [DATA_W-1:0]   decData_d;
   status_e             decStatus_d;
   logic                decDouble_d;
   logic                outXfer;

   hsiao_syndrome_calc u_syn (
      .code_i     (in_code),
      .syndrome_o (syndrome)
   );

   // Both stages move together, so a stalled output freezes the whole pipe.
   assign advance = !outValid_q || out_ready;
   assign in_ready = advance;
   assign outXfer  = outValid_q && out_ready;

   always_comb begin
      flip        = '0;
      colMatch    = 1'b0;
      decPos_d    = 4'hF;
      decDouble_d = 1'b0;
      decStatus_d = ST_CLEAN;
      for (int i = 0; i < CODE_W; i++) begin
         if (s1Syn_q == H_COL[i]) begin
            flip[i]  = 1'b1;
            colMatch = 1'b1;
            decPos_d = 4'(i);
         end
      end
      decData_d = s1Code_q[CODE_W-1:SYN_W] ^ flip[CODE_W-1:SYN_W];
      if (s1Syn_q == '0) begin
         decStatus_d = ST_CLEAN;
      end else if (colMatch) begin
         decStatus_d = ST_CE;
      end else begin
         // Even-weight syndromes can only come from an even number of flips.
         decStatus_d = ST_UE;
         decDouble_d = ~(^s1Syn_q);
         decData_d   = UE_PASS_RAW ? s1Code_q[CODE_W-1:SYN_W] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1Valid_q   <= 1'b0;
         s1Code_q    <= '0;
         s1Syn_q     <= '0;
         outValid_q  <= 1'b0;
         outData_q   <= '0;
         outStatus_q <= ST_CLEAN;
         outDouble_q <= 1'b0;
         outSyn_q    <= '0;
         outPos_q    <= 4'hF;
      end else if (advance) begin
         s1Valid_q  <= in_valid;
         s1Code_q   <= in_code;
         s1Syn_q    <= syndrome;
         outValid_q <= s1Valid_q;
         if (s1Valid_q) begin
            outData_q   <= decData_d;
            outStatus_q <= decStatus_d;
            outDouble_q <= decDouble_d;
            outSyn_q    <= s1Syn_q;
            outPos_q    <= decPos_d;
         end
      end
   end

   // A clear wins over an increment landing in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clear) begin
         ceCount_q <= '0;
         ueCount_q <= '0;
      end else if (outXfer) begin
         if (outStatus_q == ST_CE && ceCount_q != '1) ceCount_q <= ceCount_q + 1'b1;
         if (outStatus_q == ST_UE && ueCount_q != '1) ueCount_q <= ueCount_q + 1'b1;
      end
   end

   assign out_valid    = outValid_q;
   assign out_data     = outData_q;
   assign out_status   = outStatus_q;
   assign out_double   = outDouble_q;
   assign out_syndrome = outSyn_q;
   assign out_err_pos  = outPos_q;
   assign ce_count     = ceCount_q;
   assign ue_count     = ueCount_q;

endmodule

// File: tb/tb_hsiao_code_decoder.sv
// Scoreboard bench for hsiao_code_decoder: inputs are driven after the rising edge,
// a monitor on the falling edge pops expected words and tracks counter expectations.
module tb_hsiao_code_decoder;

   localparam int CW = 4;

   typedef struct {
      logic [7:0] data;
      logic [1:0] status;
      logic       dbl;
      logic [4:0] syn;
      logic [3:0] pos;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [12:0]   in_code = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [7:0]    out_data;
   logic [1:0]    out_status;
   logic          out_double;
   logic [4:0]    out_syndrome;
   logic [3:0]    out_err_pos;
   logic          cnt_clear = 1'b0;
   logic [CW-1:0] ce_count;
   logic [CW-1:0] ue_count;

   int      checks = 0;
   int      errors = 0;
   exp_t    scoreQ[$];
   exp_t    pendExp;
   exp_t    saved;
   logic    savedValid;
   logic    stalledPrev = 1'b0;
   logic    rstHit = 1'b0;
   int      expCe = 0;
   int      expUe = 0;

   hsiao_code_decoder #(.CNT_W(CW), .UE_PASS_RAW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_status(out_status),
      .out_double(out_double), .out_syndrome(out_syndrome), .out_err_pos(out_err_pos),
      .cnt_clear(cnt_clear), .ce_count(ce_count), .ue_count(ue_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: parity straight from the equations; correction found by trying
   // every single-bit flip and keeping the one that yields a valid codeword.
   function automatic logic [4:0] refParity(input logic [7:0] d);
      return {d[7]^d[6]^d[5]^d[4], d[7]^d[3]^d[2]^d[1], d[6]^d[5]^d[2]^d[1]^d[0],
              d[6]^d[4]^d[3]^d[1]^d[0], d[7]^d[5]^d[4]^d[3]^d[2]^d[0]};
   endfunction

   function automatic exp_t refDecode(input logic [12:0] c);
      exp_t e;
      logic [12:0] one = 13'd1;
      logic [12:0] t;
      e.syn = refParity(c[12:5]) ^ c[4:0];
      e.data = c[12:5];
      e.status = 2'b00;
      e.dbl = 1'b0;
      e.pos = 4'hF;
      if (e.syn != 5'd0) begin
         e.status = 2'b10;
         e.dbl = ($countones(e.syn) % 2) == 0;
         for (int k = 0; k < 13; k++) begin
            t = c ^ (one << k);
            if (refParity(t[12:5]) == t[4:0]) begin
               e.status = 2'b01;
               e.dbl = 1'b0;
               e.data = t[12:5];
               e.pos = 4'(k);
            end
         end
      end
      return e;
   endfunction

   function automatic logic [12:0] randCode(input int nflip);
      logic [7:0]  d = 8'($urandom);
      logic [12:0] c = {d, refParity(d)};
      logic [12:0] one = 13'd1;
      for (int j = 0; j < nflip; j++) c = c ^ (one << $urandom_range(0, 12));
      return c;
   endfunction

   // Offers one word and waits (bounded) for it to be accepted; in_valid stays high.
   task automatic applyStimulus(input logic [12:0] code, input exp_t e, input bit randReady);
      bit acc = 0;
      in_valid = 1'b1;
      in_code  = code;
      pendExp  = e;
      for (int n = 0; n < 200 && !acc; n++) begin
         if (randReady) out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
      end
      if (!acc) begin
         checks++; errors++;
         $display("[TB] FAIL accept timeout actual=0 required=1");
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   function automatic exp_t mk(input logic [7:0] d, input logic [1:0] s, input logic db,
                               input logic [4:0] sy, input logic [3:0] p);
      exp_t e;
      e.data = d; e.status = s; e.dbl = db; e.syn = sy; e.pos = p;
      return e;
   endfunction

   always @(posedge clk) begin
      rstHit = !rst_n;
      if (!rst_n) scoreQ.delete();
      else if (in_valid && in_ready) scoreQ.push_back(pendExp);
   end

   always @(negedge clk) begin
      exp_t e;
      if (rstHit) begin
         checkOutput("rst out_valid", out_valid, 0);
         checkOutput("rst out_data", out_data, 0);
         checkOutput("rst out_status", out_status, 0);
         checkOutput("rst out_double", out_double, 0);
         checkOutput("rst out_syndrome", out_syndrome, 0);
         checkOutput("rst out_err_pos", out_err_pos, 4'hF);
         checkOutput("rst ce_count", ce_count, 0);
         checkOutput("rst ue_count", ue_count, 0);
         expCe = 0; expUe = 0; stalledPrev = 1'b0;
      end
      if (rst_n) begin
         checkOutput("ce_count", ce_count, expCe);
         checkOutput("ue_count", ue_count, expUe);
         checkOutput("in_ready", in_ready, !out_valid || out_ready);
         if (stalledPrev) begin
            checkOutput("stall out_valid", out_valid, 1);
            checkOutput("stall data", out_data, saved.data);
            checkOutput("stall status", out_status, saved.status);
            checkOutput("stall syndrome", out_syndrome, saved.syn);
            checkOutput("stall err_pos", out_err_pos, saved.pos);
         end
         stalledPrev = 1'b0;
         if (out_valid && out_ready) begin
            if (scoreQ.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL unexpected output actual=%0h required=none", out_data);
            end else begin
               e = scoreQ.pop_front();
               checkOutput("out_data", out_data, e.data);
               checkOutput("out_status", out_status, e.status);
               checkOutput("out_double", out_double, e.dbl);
               checkOutput("out_syndrome", out_syndrome, e.syn);
               checkOutput("out_err_pos", out_err_pos, e.pos);
               if (e.status == 2'b01 && expCe < (1 << CW) - 1) expCe++;
               if (e.status == 2'b10 && expUe < (1 << CW) - 1) expUe++;
            end
         end else if (out_valid) begin
            saved.data = out_data; saved.status = out_status;
            saved.syn = out_syndrome; saved.pos = out_err_pos;
            stalledPrev = 1'b1;
         end
         if (cnt_clear) begin expCe = 0; expUe = 0; end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [12:0] words [8];
      int k;
      bit acc;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed words with hand-derived results.
      applyStimulus(13'h14A6, mk(8'hA5, 2'b00, 1'b0, 5'b00000, 4'hF), 0);
      applyStimulus(13'h10A6, mk(8'hA5, 2'b01, 1'b0, 5'b10101, 4'd10), 0);
      applyStimulus(13'h14A5, mk(8'hA5, 2'b10, 1'b1, 5'b00011, 4'hF), 0);
      applyStimulus(13'h14BA, mk(8'hA5, 2'b10, 1'b0, 5'b11100, 4'hF), 0);
      idle(4);

      // Eight-word stream with a three-cycle sink stall in the middle.
      for (int i = 0; i < 8; i++) words[i] = randCode($urandom_range(0, 2));
      k = 0;
      for (int cyc = 0; cyc < 60 && k < 8; cyc++) begin
         out_ready = !(cyc >= 4 && cyc < 7);
         in_valid  = 1'b1;
         in_code   = words[k];
         pendExp   = refDecode(words[k]);
         @(negedge clk);
         if (out_valid && !out_ready) checkOutput("stalled in_ready", in_ready, 0);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) k++;
      end
      checkOutput("stream accepted", k, 8);
      out_ready = 1'b1;
      idle(4);

      // Randomised traffic with a random sink.
      for (int i = 0; i < 300; i++) begin
         logic [12:0] c = randCode($urandom_range(0, 3));
         applyStimulus(c, refDecode(c), 1);
      end
      out_ready = 1'b1;
      idle(4);

      // Drive the CE counter into saturation.
      for (int i = 0; i < 20; i++) begin
         logic [12:0] c = randCode(1);
         while (refDecode(c).status != 2'b01) c = randCode(1);
         applyStimulus(c, refDecode(c), 0);
      end
      idle(4);
      @(negedge clk) checkOutput("ce saturated", ce_count, 4'hF);
      @(posedge clk); #1;

      // Clear coincident with a CE transfer.
      out_ready = 1'b0;
      applyStimulus(13'h10A6, mk(8'hA5, 2'b01, 1'b0, 5'b10101, 4'd10), 0);
      in_valid = 1'b0;
      for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
      @(posedge clk); #1;
      cnt_clear = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      cnt_clear = 1'b0;
      @(negedge clk) checkOutput("ce after clear", ce_count, 0);
      @(posedge clk); #1;

      // Reset with words in flight.
      out_ready = 1'b0;
      applyStimulus(13'h10A6, mk(8'hA5, 2'b01, 1'b0, 5'b10101, 4'd10), 0);
      applyStimulus(13'h14A5, mk(8'hA5, 2'b10, 1'b1, 5'b00011, 4'hF), 0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk) checkOutput("in_ready after reset", in_ready, 1);
      @(posedge clk); #1;
      applyStimulus(13'h14A6, mk(8'hA5, 2'b00, 1'b0, 5'b00000, 4'hF), 0);
      in_valid = 1'b0;

      for (int n = 0; n < 50 && scoreQ.size() != 0; n++) @(posedge clk);
      idle(2);
      checkOutput("scoreboard drained", scoreQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
